mem_port_arbiter: RTL and testbench

Arbiter and sequencer for a single-port, unified, word-wide memory shared by three requesters: instruction fetch (IF), load/store unit (LS) and program loader (LD). It serialises requests onto one memory port with one outstanding transaction, fixed-latency read timing and a request/grant/done handshake. IF gets an anti-starvation override. It sits between the core's IMEM/DMEM access points and a shared RAM macro when the core is built for multi-cycle or stalled operation.

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF / LS / LD requests onto one shared
// single-port memory. It keeps one transaction in flight, uses fixed read
// latency and a req/gnt/done handshake. IF has an anti-starvation override
// against LS.
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_done,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [31:0]   ls_wdata,
    input  logic [3:0]    ls_be,
    output logic          ls_gnt,
    output logic          ls_done,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_wdata,
    input  logic [3:0]    ld_be,
    output logic          ld_gnt,
    output logic          ld_done,
    output logic [31:0]   rsp_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {ID_NONE, ID_IF, ID_LS, ID_LD} req_id_t;

    // WAIT lasts MEM_LAT-1 cycles; the counter is loaded with one less.
    localparam logic [2:0] WAIT_LOAD  = (MEM_LAT > 1) ? 3'(MEM_LAT - 2) : 3'd0;
    localparam logic [3:0] STREAK_LIM = 4'(MAX_STREAK);

    state_t        state_q, state_d;
    logic [2:0]    wcnt_q, wcnt_d;
    req_id_t       id_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [3:0]    be_q;
    logic [3:0]    streak_q;
    logic [31:0]   rdata_q;

    logic any_req, starved, win_ls, win_if, arb_en;

    // Arbitration: LD first, then LS, then IF; a long LS streak lets IF past LS.
    assign any_req = if_req | ls_req | ld_req;
    assign starved = if_req && (streak_q >= STREAK_LIM);
    assign win_ls  = !ld_req && ls_req && !starved;
    assign win_if  = !ld_req && if_req && (!ls_req || starved);
    assign arb_en  = any_req && ((state_q == S_IDLE) || (state_q == S_RESP));

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic; IDLE and RESP both re-arbitrate straight into ACCESS.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (MEM_LAT > 1) begin
                    state_d = S_WAIT;
                    wcnt_d  = WAIT_LOAD;
                end else begin
                    state_d = S_RESP;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 3'd0) state_d = S_RESP;
                else                wcnt_d  = wcnt_q - 3'd1;
            end
            S_RESP: begin
                state_d = any_req ? S_ACCESS : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Latch the winning request at each arbitration; IF is always a full-word read.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_q    <= ID_NONE;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
        end else if (arb_en) begin
            if (ld_req) begin
                id_q    <= ID_LD;
                addr_q  <= ld_addr;
                wdata_q <= ld_wdata;
                we_q    <= ld_we;
                be_q    <= ld_be;
            end else if (win_ls) begin
                id_q    <= ID_LS;
                addr_q  <= ls_addr;
                wdata_q <= ls_wdata;
                we_q    <= ls_we;
                be_q    <= ls_be;
            end else begin
                id_q    <= ID_IF;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                be_q    <= 4'hF;
            end
        end
    end

    // Starvation counter: counts LS grants that passed over a waiting IF, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_q <= 4'd0;
        end else if (arb_en) begin
            if (!if_req || win_if)                 streak_q <= 4'd0;
            else if (win_ls && streak_q != 4'hF)   streak_q <= streak_q + 4'd1;
        end
    end

    // Capture read data in the RESP cycle, MEM_LAT cycles after ACCESS.
    always_ff @(posedge clk) begin
        if (rst)                              rdata_q <= 32'h0;
        else if (state_q == S_RESP && !we_q)  rdata_q <= mem_rdata;
    end

    // Output decode: memory strobes only in ACCESS, handshakes by latched id.
    always_comb begin
        mem_en    = (state_q == S_ACCESS);
        mem_we    = mem_en && we_q;
        mem_be    = mem_en ? be_q : 4'h0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if_gnt    = mem_en && (id_q == ID_IF);
        ls_gnt    = mem_en && (id_q == ID_LS);
        ld_gnt    = mem_en && (id_q == ID_LD);
        if_done   = (state_q == S_RESP) && (id_q == ID_IF);
        ls_done   = (state_q == S_RESP) && (id_q == ID_LS);
        ld_done   = (state_q == S_RESP) && (id_q == ID_LD);
        rsp_rdata = rdata_q;
        if (state_q == S_RESP) rsp_rdata = we_q ? 32'h0 : mem_rdata;
        busy      = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: instance A (MEM_LAT=1) and instance B
// (MEM_LAT=3) share the requester inputs, each with its own memory model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, ls_req, ls_we, ld_req, ld_we;
    logic [15:0] if_addr, ls_addr, ld_addr;
    logic [31:0] ls_wdata, ld_wdata;
    logic [3:0]  ls_be, ld_be;

    logic        if_gnt_a, if_done_a, ls_gnt_a, ls_done_a, ld_gnt_a, ld_done_a;
    logic        mem_en_a, mem_we_a, busy_a;
    logic [15:0] mem_addr_a;
    logic [31:0] mem_wdata_a, rsp_a, rd_a;
    logic [3:0]  mem_be_a;

    logic        if_gnt_b, if_done_b, ls_gnt_b, ls_done_b, ld_gnt_b, ld_done_b;
    logic        mem_en_b, mem_we_b, busy_b;
    logic [15:0] mem_addr_b;
    logic [31:0] mem_wdata_b, rsp_b;
    logic [3:0]  mem_be_b;
    logic [31:0] pipe_b [0:2];

    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(16), .MEM_LAT(1), .MAX_STREAK(4)) dut_a (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a), .if_done(if_done_a),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt_a), .ls_done(ls_done_a),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_be(ld_be), .ld_gnt(ld_gnt_a), .ld_done(ld_done_a),
        .rsp_rdata(rsp_a), .mem_en(mem_en_a), .mem_we(mem_we_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_be(mem_be_a),
        .mem_rdata(rd_a), .busy(busy_a)
    );

    mem_port_arbiter #(.AW(16), .MEM_LAT(3), .MAX_STREAK(4)) dut_b (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b), .if_done(if_done_b),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_be(ls_be), .ls_gnt(ls_gnt_b), .ls_done(ls_done_b),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_be(ld_be), .ld_gnt(ld_gnt_b), .ld_done(ld_done_b),
        .rsp_rdata(rsp_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_be(mem_be_b),
        .mem_rdata(pipe_b[2]), .busy(busy_b)
    );

    // Memory A: read data valid 1 cycle after the strobe; byte-masked writes.
    always @(posedge clk) begin
        if (mem_en_a) begin
            rd_a <= mem_a[mem_addr_a[9:0]];
            if (mem_we_a)
                for (int i = 0; i < 4; i++)
                    if (mem_be_a[i]) mem_a[mem_addr_a[9:0]][8*i +: 8] = mem_wdata_a[8*i +: 8];
        end else begin
            rd_a <= 32'hxxxxxxxx;
        end
    end

    // Memory B: read data valid 3 cycles after the strobe.
    always @(posedge clk) begin
        pipe_b[0] <= mem_en_b ? mem_b[mem_addr_b[9:0]] : 32'hxxxxxxxx;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        if (mem_en_b && mem_we_b)
            for (int i = 0; i < 4; i++)
                if (mem_be_b[i]) mem_b[mem_addr_b[9:0]][8*i +: 8] = mem_wdata_b[8*i +: 8];
    end

    // One line per completed transaction.
    always @(negedge clk) begin
        if (if_done_a | ls_done_a | ld_done_a)
            $display("[A] t=%0t done ld/ls/if=%b%b%b rdata=%h", $time, ld_done_a, ls_done_a, if_done_a, rsp_a);
        if (if_done_b | ls_done_b | ld_done_b)
            $display("[B] t=%0t done ld/ls/if=%b%b%b rdata=%h", $time, ld_done_b, ls_done_b, if_done_b, rsp_b);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // g and d are {ld, ls, if}.
    task automatic chk_a(input string tag, input logic [2:0] g, input logic [2:0] d, input logic b);
        check({tag, "_gnt"},  {29'd0, ld_gnt_a, ls_gnt_a, if_gnt_a}, {29'd0, g});
        check({tag, "_done"}, {29'd0, ld_done_a, ls_done_a, if_done_a}, {29'd0, d});
        check({tag, "_busy"}, {31'd0, busy_a}, {31'd0, b});
    endtask

    task automatic chk_b(input string tag, input logic [2:0] g, input logic [2:0] d, input logic b);
        check({tag, "_gnt"},  {29'd0, ld_gnt_b, ls_gnt_b, if_gnt_b}, {29'd0, g});
        check({tag, "_done"}, {29'd0, ld_done_b, ls_done_b, if_done_b}, {29'd0, d});
        check({tag, "_busy"}, {31'd0, busy_b}, {31'd0, b});
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ld_req = 1'b0; ld_we = 1'b0;
        if_addr = 16'h0; ls_addr = 16'h0; ld_addr = 16'h0;
        ls_wdata = 32'h0; ld_wdata = 32'h0; ls_be = 4'h0; ld_be = 4'h0;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[16'h0010] = 32'h00500093;
        mem_a[16'h0020] = 32'h11111111;
        mem_a[16'h0030] = 32'h22222222;
        for (int i = 0; i < 3; i++) mem_b[16'h0040 + i] = 32'hA0000000 + i;

        // Reset state
        step(); step();
        chk_a("rst_a", 3'b000, 3'b000, 1'b0);
        check("rst_a_en", {31'd0, mem_en_a}, 32'd0);
        check("rst_a_we", {31'd0, mem_we_a}, 32'd0);
        check("rst_a_rsp", rsp_a, 32'h0);
        chk_b("rst_b", 3'b000, 3'b000, 1'b0);
        rst = 1'b0;

        // Single IF read, MEM_LAT=1
        if_req = 1'b1; if_addr = 16'h0010;
        step();
        chk_a("if_acc", 3'b001, 3'b000, 1'b1);
        check("if_acc_addr", {16'd0, mem_addr_a}, 32'h0010);
        check("if_acc_en", {31'd0, mem_en_a}, 32'd1);
        check("if_acc_we", {31'd0, mem_we_a}, 32'd0);
        check("if_acc_be", {28'd0, mem_be_a}, 32'hF);
        if_req = 1'b0;
        step();
        chk_a("if_resp", 3'b000, 3'b001, 1'b1);
        check("if_resp_data", rsp_a, 32'h00500093);
        check("if_resp_en", {31'd0, mem_en_a}, 32'd0);
        step();
        chk_a("if_idle", 3'b000, 3'b000, 1'b0);

        // LS partial write then read back
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0100; ls_wdata = 32'hDEADBEEF; ls_be = 4'b0011;
        step();
        chk_a("lsw_acc", 3'b010, 3'b000, 1'b1);
        check("lsw_we", {31'd0, mem_we_a}, 32'd1);
        check("lsw_be", {28'd0, mem_be_a}, 32'h3);
        check("lsw_wdata", mem_wdata_a, 32'hDEADBEEF);
        check("lsw_addr", {16'd0, mem_addr_a}, 32'h0100);
        ls_req = 1'b0; ls_we = 1'b0;
        step();
        chk_a("lsw_resp", 3'b000, 3'b010, 1'b1);
        check("lsw_rsp", rsp_a, 32'h0);
        check("lsw_resp_we", {31'd0, mem_we_a}, 32'd0);
        check("lsw_resp_be", {28'd0, mem_be_a}, 32'h0);
        check("lsw_wdata_hold", mem_wdata_a, 32'hDEADBEEF);
        step();
        ls_req = 1'b1; ls_addr = 16'h0100;
        step();
        chk_a("lsr_acc", 3'b010, 3'b000, 1'b1);
        check("lsr_we", {31'd0, mem_we_a}, 32'd0);
        ls_req = 1'b0;
        step();
        chk_a("lsr_resp", 3'b000, 3'b010, 1'b1);
        check("lsr_low", {16'd0, rsp_a[15:0]}, 32'hBEEF);
        check("lsr_word", rsp_a, 32'h0000BEEF);
        step();

        // Three-way contention: LD, then LS, then IF
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 16'h0020;
        ls_req = 1'b1; ls_addr = 16'h0030;
        if_req = 1'b1; if_addr = 16'h0010;
        step();
        chk_a("c_ld_acc", 3'b100, 3'b000, 1'b1);
        check("c_ld_addr", {16'd0, mem_addr_a}, 32'h0020);
        ld_req = 1'b0;
        step();
        chk_a("c_ld_resp", 3'b000, 3'b100, 1'b1);
        check("c_ld_data", rsp_a, 32'h11111111);
        step();
        chk_a("c_ls_acc", 3'b010, 3'b000, 1'b1);
        check("c_ls_addr", {16'd0, mem_addr_a}, 32'h0030);
        ls_req = 1'b0;
        step();
        chk_a("c_ls_resp", 3'b000, 3'b010, 1'b1);
        check("c_ls_data", rsp_a, 32'h22222222);
        step();
        chk_a("c_if_acc", 3'b001, 3'b000, 1'b1);
        check("c_if_addr", {16'd0, mem_addr_a}, 32'h0010);
        if_req = 1'b0;
        step();
        chk_a("c_if_resp", 3'b000, 3'b001, 1'b1);
        check("c_if_data", rsp_a, 32'h00500093);
        step();
        chk_a("c_idle", 3'b000, 3'b000, 1'b0);

        // Starvation: LS and IF held -> 4 LS, 1 IF, 4 LS, 1 IF
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0030;
        if_req = 1'b1; if_addr = 16'h0010;
        step();
        for (int k = 0; k < 10; k++) begin
            logic [2:0] exp_g;
            exp_g = (k == 4 || k == 9) ? 3'b001 : 3'b010;
            chk_a($sformatf("stv%0d_acc", k), exp_g, 3'b000, 1'b1);
            if (k == 9) begin
                ls_req = 1'b0;
                if_req = 1'b0;
            end
            step();
            chk_a($sformatf("stv%0d_resp", k), 3'b000, exp_g, 1'b1);
            step();
        end
        chk_a("stv_idle", 3'b000, 3'b000, 1'b0);

        // Instance B: reset in the middle of WAIT abandons the read
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk_b("b_clean", 3'b000, 3'b000, 1'b0);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 16'h0040;
        step();
        chk_b("ab_acc", 3'b010, 3'b000, 1'b1);
        ls_req = 1'b0;
        step();
        chk_b("ab_wait", 3'b000, 3'b000, 1'b1);
        rst = 1'b1;
        step();
        chk_b("ab_rst1", 3'b000, 3'b000, 1'b0);
        check("ab_rst_rsp", rsp_b, 32'h0);
        check("ab_rst_en", {31'd0, mem_en_b}, 32'd0);
        check("ab_rst_we", {31'd0, mem_we_b}, 32'd0);
        step();
        chk_b("ab_rst2", 3'b000, 3'b000, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_b($sformatf("ab_quiet%0d", k), 3'b000, 3'b000, 1'b0);
        end

        // Instance B: back-to-back LS reads, gnt every 4 cycles, done 3 after gnt
        ls_req = 1'b1; ls_addr = 16'h0040;
        step();
        for (int k = 0; k < 3; k++) begin
            chk_b($sformatf("bb%0d_acc", k), 3'b010, 3'b000, 1'b1);
            check($sformatf("bb%0d_addr", k), {16'd0, mem_addr_b}, 32'h0040 + k);
            if (k < 2) ls_addr = 16'h0041 + 16'(k);
            else       ls_req = 1'b0;
            step();
            chk_b($sformatf("bb%0d_w1", k), 3'b000, 3'b000, 1'b1);
            step();
            chk_b($sformatf("bb%0d_w2", k), 3'b000, 3'b000, 1'b1);
            step();
            chk_b($sformatf("bb%0d_resp", k), 3'b000, 3'b010, 1'b1);
            check($sformatf("bb%0d_data", k), rsp_b, 32'hA0000000 + k);
            step();
        end
        chk_b("bb_idle", 3'b000, 3'b000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
